// File: rtl/regf_pkg.sv
// Shared types and helpers for the multi-port register file slice.
//
// Contents:
//   regf_state_e     - CLEAR (zeroing the array after reset) / RUN
//   regf_addr_width  - address width for a given register count
//   regf_addr_t      - address type for the default 32-entry file
//   regf_data_t      - data type for the default 32-bit file
package regf_pkg;

    localparam int REGF_XLEN  = 32;
    localparam int REGF_NREGS = 32;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } regf_state_e;

    // Keeps at least one address bit so a degenerate file still elaborates.
    function automatic int regf_addr_width(input int nregs);
        return (nregs > 1) ? $clog2(nregs) : 1;
    endfunction

    localparam int REGF_AW = regf_addr_width(REGF_NREGS);

    typedef logic [REGF_AW-1:0]   regf_addr_t;
    typedef logic [REGF_XLEN-1:0] regf_data_t;

endpackage

// File: rtl/regf_sb.sv
// Pending-write scoreboard: one bit per register, set when an instruction
// writing that register issues and cleared when its result is written back.
//
// Ports:
//   clk       in   clock
//   clr_all   in   clears every entry (takes priority over everything else)
//   clr_en    in   NCLR per-port clear strobes
//   clr_addr  in   NCLR clear addresses
//   set_en    in   set strobe
//   set_addr  in   set address; a set beats a same-cycle clear of that entry
//   lk_addr   in   NLK lookup addresses
//   lk_busy   out  NLK current pending flags (combinational lookup)
module regf_sb
    import regf_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int NCLR  = 3,
    parameter int NLK   = 2,
    localparam int AW   = regf_addr_width(NREGS)
) (
    input  logic                     clk,
    input  logic                     clr_all,
    input  logic [NCLR-1:0]          clr_en,
    input  logic [NCLR-1:0][AW-1:0]  clr_addr,
    input  logic                     set_en,
    input  logic [AW-1:0]            set_addr,
    input  logic [NLK-1:0][AW-1:0]   lk_addr,
    output logic [NLK-1:0]           lk_busy
);

    logic [NREGS-1:0] sb;

    // The set is applied after the clears so it wins on an address collision.
    always_ff @(posedge clk) begin
        if (clr_all) begin
            sb <= '0;
        end else begin
            for (int i = 0; i < NCLR; i++) begin
                if (clr_en[i]) begin
                    sb[clr_addr[i]] <= 1'b0;
                end
            end
            if (set_en) begin
                sb[set_addr] <= 1'b1;
            end
        end
    end

    always_comb begin
        lk_busy = '0;
        for (int j = 0; j < NLK; j++) begin
            lk_busy[j] = sb[lk_addr[j]];
        end
    end

endmodule

// File: rtl/regf_mp.sv
// Multi-port register file with registered reads, write-to-read forwarding,
// a pending-write scoreboard, and a post-reset clear sequence that zeroes one
// entry per cycle instead of resetting the whole array at once.
//
// Ports:
//   clk          in   clock, all logic on posedge
//   rst          in   synchronous active-high reset, restarts the clear sequence
//   r_enable     in   1: capture new read results, 0: hold r_data/r_busy
//   r_addr       in   NRD read addresses
//   r_data       out  NRD registered read data
//   r_busy       out  NRD registered pending flags for r_addr
//   w_enable     in   NWR write strobes
//   w_addr       in   NWR write addresses
//   w_data       in   NWR write data
//   sb_set_en    in   mark sb_set_addr as pending
//   sb_set_addr  in   destination register of the issued instruction
//   ready        out  0 while clearing, 1 in RUN
module regf_mp
    import regf_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = regf_addr_width(NREGS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      r_enable,
    input  logic [NRD-1:0][AW-1:0]    r_addr,
    output logic [NRD-1:0][XLEN-1:0]  r_data,
    output logic [NRD-1:0]            r_busy,
    input  logic [NWR-1:0]            w_enable,
    input  logic [NWR-1:0][AW-1:0]    w_addr,
    input  logic [NWR-1:0][XLEN-1:0]  w_data,
    input  logic                      sb_set_en,
    input  logic [AW-1:0]             sb_set_addr,
    output logic                      ready
);

    regf_state_e                state;
    logic [AW-1:0]              clr_idx;
    logic [XLEN-1:0]            regs [NREGS];

    logic [NWR-1:0]             w_eff;
    logic [NRD-1:0]             fwd_hit;
    logic [NRD-1:0][XLEN-1:0]   fwd_data;
    logic [NRD-1:0]             sb_busy;

    logic [NWR:0]               sb_clr_en;
    logic [NWR:0][AW-1:0]       sb_clr_addr;
    logic                       sb_set_eff;

    function automatic logic is_zero_reg(input logic [AW-1:0] addr);
        return (ZERO_REG != 0) && (addr == '0);
    endfunction

    // A write only counts in RUN and never targets the hardwired zero entry.
    always_comb begin
        w_eff = '0;
        for (int i = 0; i < NWR; i++) begin
            w_eff[i] = (state == RUN) && w_enable[i] && !is_zero_reg(w_addr[i]);
        end
    end

    // Read mux with forwarding; scanning ports upward lets the highest
    // effective write port win, matching the array update order.
    always_comb begin
        fwd_hit  = '0;
        fwd_data = '0;
        for (int j = 0; j < NRD; j++) begin
            fwd_data[j] = is_zero_reg(r_addr[j]) ? '0 : regs[r_addr[j]];
            for (int i = 0; i < NWR; i++) begin
                if (w_eff[i] && (w_addr[i] == r_addr[j])) begin
                    fwd_hit[j]  = 1'b1;
                    fwd_data[j] = w_data[i];
                end
            end
        end
    end

    // Clear port 0 walks the array during CLEAR; the others follow writeback.
    assign sb_clr_en   = {w_eff, (state == CLEAR)};
    assign sb_clr_addr = {w_addr, clr_idx};
    assign sb_set_eff  = (state == RUN) && sb_set_en && !is_zero_reg(sb_set_addr);

    regf_sb #(
        .NREGS (NREGS),
        .NCLR  (NWR + 1),
        .NLK   (NRD)
    ) u_sb (
        .clk      (clk),
        .clr_all  (rst),
        .clr_en   (sb_clr_en),
        .clr_addr (sb_clr_addr),
        .set_en   (sb_set_eff),
        .set_addr (sb_set_addr),
        .lk_addr  (r_addr),
        .lk_busy  (sb_busy)
    );

    // The array itself has no reset; the CLEAR state zeroes it entry by entry.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                regs[clr_idx] <= '0;
            end else begin
                for (int i = 0; i < NWR; i++) begin
                    if (w_eff[i]) begin
                        regs[w_addr[i]] <= w_data[i];
                    end
                end
            end
        end
    end

    // Control FSM and registered read outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_idx <= '0;
            ready   <= 1'b0;
            r_data  <= '0;
            r_busy  <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    r_data  <= '0;
                    r_busy  <= '0;
                    clr_idx <= clr_idx + 1'b1;
                    if (clr_idx == AW'(NREGS - 1)) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                    ready <= 1'b1;
                    if (r_enable) begin
                        r_data <= fwd_data;
                        // A same-cycle writeback retires the hazard being looked up.
                        r_busy <= sb_busy & ~fwd_hit;
                    end
                end
                default: begin
                    state   <= CLEAR;
                    clr_idx <= '0;
                    ready   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regf_mp.sv
// Self-checking bench for regf_mp: each driven cycle is run through a
// behavioural model and the expected post-edge outputs are queued; a monitor
// pops one entry after every rising edge and compares it with the DUT.
module tb_regf_mp;

    localparam int XLEN     = 32;
    localparam int NREGS    = 32;
    localparam int NRD      = 2;
    localparam int NWR      = 2;
    localparam int ZERO_REG = 1;
    localparam int AW       = $clog2(NREGS);

    logic                      clk;
    logic                      rst;
    logic                      r_enable;
    logic [NRD-1:0][AW-1:0]    r_addr;
    logic [NRD-1:0][XLEN-1:0]  r_data;
    logic [NRD-1:0]            r_busy;
    logic [NWR-1:0]            w_enable;
    logic [NWR-1:0][AW-1:0]    w_addr;
    logic [NWR-1:0][XLEN-1:0]  w_data;
    logic                      sb_set_en;
    logic [AW-1:0]             sb_set_addr;
    logic                      ready;

    regf_mp #(
        .XLEN     (XLEN),
        .NREGS    (NREGS),
        .NRD      (NRD),
        .NWR      (NWR),
        .ZERO_REG (ZERO_REG)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .r_enable    (r_enable),
        .r_addr      (r_addr),
        .r_data      (r_data),
        .r_busy      (r_busy),
        .w_enable    (w_enable),
        .w_addr      (w_addr),
        .w_data      (w_data),
        .sb_set_en   (sb_set_en),
        .sb_set_addr (sb_set_addr),
        .ready       (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic                      ready;
        logic [NRD-1:0][XLEN-1:0]  data;
        logic [NRD-1:0]            busy;
        bit                        dir_data_en;
        int                        dir_port;
        logic [XLEN-1:0]           dir_data;
        bit                        dir_busy_en;
        logic                      dir_busy;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model of the register file contents and outputs.
    logic [XLEN-1:0]           m_regs [NREGS];
    bit                        m_sb   [NREGS];
    bit                        m_clear = 1'b1;
    int                        m_pos   = 0;
    logic [NRD-1:0][XLEN-1:0]  m_rdata = '0;
    logic [NRD-1:0]            m_rbusy = '0;
    bit                        m_ready = 1'b0;

    // Spot-check expectations attached to the next queued entry.
    bit              dir_data_en = 1'b0;
    int              dir_port    = 0;
    logic [XLEN-1:0] dir_data    = '0;
    bit              dir_busy_en = 1'b0;
    logic            dir_busy    = 1'b0;

    task automatic expectDir(input int port, input logic [XLEN-1:0] data,
                             input bit busy_en, input logic busy);
        dir_data_en = 1'b1;
        dir_port    = port;
        dir_data    = data;
        dir_busy_en = busy_en;
        dir_busy    = busy;
    endtask

    task automatic idle();
        rst         = 1'b0;
        r_enable    = 1'b0;
        r_addr      = '0;
        w_enable    = '0;
        w_addr      = '0;
        w_data      = '0;
        sb_set_en   = 1'b0;
        sb_set_addr = '0;
    endtask

    // Evaluate the model on the inputs currently driven, queue the outputs the
    // DUT must show after the coming edge, then move to the next drive point.
    task automatic applyStimulus();
        exp_t            e;
        bit              eff [NWR];
        bit              hit;
        logic [XLEN-1:0] val;
        int              a;
        if (rst) begin
            m_clear = 1'b1;
            m_pos   = 0;
            for (int k = 0; k < NREGS; k++) m_sb[k] = 1'b0;
            m_rdata = '0;
            m_rbusy = '0;
            m_ready = 1'b0;
        end else if (m_clear) begin
            m_regs[m_pos] = '0;
            m_sb[m_pos]   = 1'b0;
            m_pos++;
            m_rdata = '0;
            m_rbusy = '0;
            if (m_pos == NREGS) begin
                m_clear = 1'b0;
                m_ready = 1'b1;
            end
        end else begin
            for (int i = 0; i < NWR; i++) begin
                eff[i] = w_enable[i] && !(ZERO_REG != 0 && w_addr[i] == 0);
            end
            if (r_enable) begin
                for (int j = 0; j < NRD; j++) begin
                    a   = int'(r_addr[j]);
                    hit = 1'b0;
                    val = (ZERO_REG != 0 && a == 0) ? '0 : m_regs[a];
                    for (int i = 0; i < NWR; i++) begin
                        if (eff[i] && int'(w_addr[i]) == a) begin
                            hit = 1'b1;
                            val = w_data[i];
                        end
                    end
                    m_rdata[j] = val;
                    m_rbusy[j] = m_sb[a] && !hit;
                end
            end
            for (int i = 0; i < NWR; i++) begin
                if (eff[i]) begin
                    m_regs[int'(w_addr[i])] = w_data[i];
                    m_sb[int'(w_addr[i])]   = 1'b0;
                end
            end
            if (sb_set_en && !(ZERO_REG != 0 && sb_set_addr == 0)) begin
                m_sb[int'(sb_set_addr)] = 1'b1;
            end
        end
        e.ready       = m_ready;
        e.data        = m_rdata;
        e.busy        = m_rbusy;
        e.dir_data_en = dir_data_en;
        e.dir_port    = dir_port;
        e.dir_data    = dir_data;
        e.dir_busy_en = dir_busy_en;
        e.dir_busy    = dir_busy;
        exp_q.push_back(e);
        dir_data_en = 1'b0;
        dir_busy_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic checkOutput(input exp_t e);
        n_checks++;
        if (ready !== e.ready) begin
            n_fail++;
            $display("[TB] FAIL ready @%0t: got %b expected %b", $time, ready, e.ready);
        end
        for (int j = 0; j < NRD; j++) begin
            n_checks++;
            if (r_data[j] !== e.data[j]) begin
                n_fail++;
                $display("[TB] FAIL r_data[%0d] @%0t: got %h expected %h", j, $time, r_data[j], e.data[j]);
            end
            n_checks++;
            if (r_busy[j] !== e.busy[j]) begin
                n_fail++;
                $display("[TB] FAIL r_busy[%0d] @%0t: got %b expected %b", j, $time, r_busy[j], e.busy[j]);
            end
        end
        if (e.dir_data_en) begin
            n_checks++;
            if (r_data[e.dir_port] !== e.dir_data) begin
                n_fail++;
                $display("[TB] FAIL directed_data[%0d] @%0t: got %h expected %h",
                         e.dir_port, $time, r_data[e.dir_port], e.dir_data);
            end
        end
        if (e.dir_busy_en) begin
            n_checks++;
            if (r_busy[e.dir_port] !== e.dir_busy) begin
                n_fail++;
                $display("[TB] FAIL directed_busy[%0d] @%0t: got %b expected %b",
                         e.dir_port, $time, r_busy[e.dir_port], e.dir_busy);
            end
        end
    endtask

    // Monitor: outputs update on every rising edge, so one entry is consumed per edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checkOutput(e);
            end
        end
    end

    function automatic logic [AW-1:0] randAddr();
        if ($urandom_range(0, 1) == 1) return AW'($urandom_range(0, 7));
        return AW'($urandom_range(0, NREGS - 1));
    endfunction

    initial begin
        idle();

        // Reset, then the clear sequence with reads and ignored writes/sets.
        $display("[TB] reset and clear sequence");
        rst = 1'b1;
        applyStimulus();
        for (int c = 0; c < NREGS + 1; c++) begin
            idle();
            r_enable    = 1'b1;
            r_addr[0]   = randAddr();
            r_addr[1]   = randAddr();
            w_enable    = NWR'($urandom);
            w_addr[0]   = randAddr();
            w_addr[1]   = randAddr();
            w_data[0]   = $urandom;
            w_data[1]   = $urandom;
            sb_set_en   = (c < NREGS);
            sb_set_addr = randAddr();
            applyStimulus();
        end

        // Forwarding of a single write, then a plain read.
        $display("[TB] forwarding");
        idle();
        w_enable  = 2'b01;
        w_addr[0] = 5;
        w_data[0] = 32'hDEADBEEF;
        r_enable  = 1'b1;
        r_addr[0] = 5;
        expectDir(0, 32'hDEADBEEF, 1'b1, 1'b0);
        applyStimulus();
        idle();
        applyStimulus();
        idle();
        r_enable  = 1'b1;
        r_addr[0] = 5;
        expectDir(0, 32'hDEADBEEF, 1'b0, 1'b0);
        applyStimulus();

        // Write-port priority and the zero register.
        $display("[TB] port priority and zero register");
        idle();
        w_enable  = 2'b11;
        w_addr[0] = 7;
        w_data[0] = 32'h11;
        w_addr[1] = 7;
        w_data[1] = 32'h22;
        r_enable  = 1'b1;
        r_addr[1] = 7;
        expectDir(1, 32'h22, 1'b0, 1'b0);
        applyStimulus();
        idle();
        r_enable  = 1'b1;
        r_addr[0] = 7;
        expectDir(0, 32'h22, 1'b0, 1'b0);
        applyStimulus();
        idle();
        w_enable  = 2'b01;
        w_addr[0] = 0;
        w_data[0] = 32'hFF;
        r_enable  = 1'b1;
        r_addr[0] = 0;
        expectDir(0, 32'h0, 1'b1, 1'b0);
        applyStimulus();
        idle();
        r_enable  = 1'b1;
        r_addr[0] = 0;
        expectDir(0, 32'h0, 1'b1, 1'b0);
        applyStimulus();

        // Scoreboard set/clear interactions.
        $display("[TB] scoreboard");
        idle();
        sb_set_en   = 1'b1;
        sb_set_addr = 9;
        applyStimulus();
        idle();
        r_enable  = 1'b1;
        r_addr[0] = 9;
        expectDir(0, 32'h0, 1'b1, 1'b1);
        applyStimulus();
        idle();
        w_enable  = 2'b10;
        w_addr[1] = 9;
        w_data[1] = 32'h99;
        r_enable  = 1'b1;
        r_addr[0] = 9;
        expectDir(0, 32'h99, 1'b1, 1'b0);
        applyStimulus();
        idle();
        sb_set_en   = 1'b1;
        sb_set_addr = 9;
        w_enable    = 2'b01;
        w_addr[0]   = 9;
        w_data[0]   = 32'h77;
        r_enable    = 1'b1;
        r_addr[0]   = 9;
        expectDir(0, 32'h77, 1'b1, 1'b0);
        applyStimulus();
        idle();
        r_enable  = 1'b1;
        r_addr[0] = 9;
        expectDir(0, 32'h77, 1'b1, 1'b1);
        applyStimulus();
        idle();
        sb_set_en   = 1'b1;
        sb_set_addr = 12;
        r_enable    = 1'b1;
        r_addr[1]   = 12;
        expectDir(1, 32'h0, 1'b1, 1'b0);
        applyStimulus();
        idle();
        r_enable  = 1'b1;
        r_addr[1] = 12;
        expectDir(1, 32'h0, 1'b1, 1'b1);
        applyStimulus();

        // Hold while r_enable is low, even when the held address is written.
        $display("[TB] read hold");
        idle();
        r_enable  = 1'b1;
        r_addr[0] = 9;
        r_addr[1] = 7;
        expectDir(0, 32'h77, 1'b1, 1'b1);
        applyStimulus();
        for (int c = 0; c < 3; c++) begin
            idle();
            r_addr[0] = randAddr();
            r_addr[1] = randAddr();
            w_enable  = 2'b01;
            w_addr[0] = 9;
            w_data[0] = 32'h100 + 32'(c);
            expectDir(0, 32'h77, 1'b1, 1'b1);
            applyStimulus();
        end

        // Reset pulsed in the middle of a clear sequence.
        $display("[TB] reset during clear");
        idle();
        w_enable  = 2'b01;
        w_addr[0] = 3;
        w_data[0] = 32'hAB;
        applyStimulus();
        idle();
        r_enable  = 1'b1;
        r_addr[0] = 3;
        expectDir(0, 32'hAB, 1'b0, 1'b0);
        applyStimulus();
        idle();
        rst = 1'b1;
        applyStimulus();
        for (int c = 0; c < 10; c++) begin
            idle();
            r_enable  = 1'b1;
            r_addr[0] = 3;
            applyStimulus();
        end
        idle();
        rst = 1'b1;
        applyStimulus();
        for (int c = 0; c < NREGS; c++) begin
            idle();
            r_enable  = 1'b1;
            r_addr[0] = 3;
            applyStimulus();
        end
        idle();
        r_enable  = 1'b1;
        r_addr[0] = 3;
        expectDir(0, 32'h0, 1'b1, 1'b0);
        applyStimulus();

        // Randomised traffic with occasional resets.
        $display("[TB] random traffic");
        for (int c = 0; c < 400; c++) begin
            idle();
            rst         = ($urandom_range(0, 299) == 0);
            r_enable    = ($urandom_range(0, 9) < 8);
            r_addr[0]   = randAddr();
            r_addr[1]   = randAddr();
            w_enable    = NWR'($urandom);
            w_addr[0]   = randAddr();
            w_addr[1]   = randAddr();
            w_data[0]   = $urandom;
            w_data[1]   = $urandom;
            sb_set_en   = ($urandom_range(0, 2) == 0);
            sb_set_addr = randAddr();
            applyStimulus();
        end

        idle();
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL queue_drain: got %0d entries left expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL timeout: got no completion expected finish before 500000");
        $fatal(1, "[TB] timeout");
    end

endmodule
